// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared MIPS core constants. The register-file geometry lives here so the
//   control unit, the jal/jr logic and the register file agree on widths and
//   on the special register indices.
//
//   WORD_W      datapath word width
//   REG_ADDR_W  register index width (32 GPRs)
//   REG_ZERO    hard-wired zero register
//   REG_RA      return-address register written by jal
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   MIPS general-purpose register file: 2**ADDR_W x WIDTH, two asynchronous
//   read ports feeding the ALU, one synchronous write port from writeback,
//   plus an asynchronous debug read port that always shows raw array contents.
//   Register 0 reads as zero regardless of what is written to it.
//
// Parameters
//   WIDTH   data width of every register and port
//   ADDR_W  register index width, depth = 2**ADDR_W
//   BYPASS  1 = a write in flight is visible on the read ports in the same
//           cycle; 0 = read ports show pre-write contents until the edge
//
// Ports
//   i_clk     clock, all state changes on the rising edge
//   i_rst_n   synchronous reset, active-low; clears the array, forces reads 0
//   i_ra1     read address port 1 (rs)      -> o_rd1 (ALU operand 1)
//   i_ra2     read address port 2 (rt)      -> o_rd2 (ALU operand 2 / store)
//   i_we      write enable
//   i_wa      write address (rd or rt)
//   i_wd      write data
//   i_dbg_ra  debug read address            -> o_dbg_rd (never bypassed)
// ---------------------------------------------------------------------------
module reg_file
    import mips_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_ra1,
    input  logic [ADDR_W-1:0] i_ra2,
    output logic [WIDTH-1:0]  o_rd1,
    output logic [WIDTH-1:0]  o_rd2,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [WIDTH-1:0]  i_wd,
    input  logic [ADDR_W-1:0] i_dbg_ra,
    output logic [WIDTH-1:0]  o_dbg_rd
);

    localparam int DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // A write to the zero register is dropped here, so mem[0] never leaves 0.
    logic wr_en;
    assign wr_en = i_we && (i_wa != '0);

    // Reset has priority: a write presented on a reset edge is discarded.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[i_wa] <= i_wd;
        end
    end

    // One read path shared by all three ports. Address 0 is decoded to zero
    // explicitly rather than relying on mem[0], so the zero register holds
    // even if the array were ever loaded some other way.
    function automatic logic [WIDTH-1:0] rf_read(input logic [ADDR_W-1:0] addr,
                                                 input logic              use_bypass);
        logic [WIDTH-1:0] val;
        if (!i_rst_n) begin
            val = '0;
        end else if (addr == '0) begin
            val = '0;
        end else if (use_bypass && wr_en && (i_wa == addr)) begin
            val = i_wd;
        end else begin
            val = mem[addr];
        end
        return val;
    endfunction

    always_comb begin
        o_rd1    = rf_read(i_ra1, BYPASS != 0);
        o_rd2    = rf_read(i_ra2, BYPASS != 0);
        // Debug port reflects committed array state only.
        o_dbg_rd = rf_read(i_dbg_ra, 1'b0);
    end

    // A write with an unknown address could corrupt any register.
    a_wa_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                  i_we |-> !$isunknown(i_wa));

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed checks of reg_file with two instances sharing stimulus: one with
//   same-cycle write forwarding, one without. A short random phase compares
//   both against a reference array.
// ---------------------------------------------------------------------------
module tb_reg_file;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ra1, ra2, wa, dbg_ra;
    logic          we;
    logic [W-1:0]  wd;
    logic [W-1:0]  rd1_b, rd2_b, dbg_b;   // BYPASS=1 instance
    logic [W-1:0]  rd1_n, rd2_n, dbg_n;   // BYPASS=0 instance

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] model [0:31];

    reg_file #(.WIDTH(W), .ADDR_W(AW), .BYPASS(1)) u_byp (
        .i_clk(clk), .i_rst_n(rst_n), .i_ra1(ra1), .i_ra2(ra2),
        .o_rd1(rd1_b), .o_rd2(rd2_b), .i_we(we), .i_wa(wa), .i_wd(wd),
        .i_dbg_ra(dbg_ra), .o_dbg_rd(dbg_b)
    );

    reg_file #(.WIDTH(W), .ADDR_W(AW), .BYPASS(0)) u_nobyp (
        .i_clk(clk), .i_rst_n(rst_n), .i_ra1(ra1), .i_ra2(ra2),
        .o_rd1(rd1_n), .o_rd2(rd2_n), .i_we(we), .i_wa(wa), .i_wd(wd),
        .i_dbg_ra(dbg_ra), .o_dbg_rd(dbg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs then change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        // Outputs forced to zero while reset is low, even with no clock yet.
        rst_n = 1'b0; ra1 = 5'd3; ra2 = 5'd4; dbg_ra = 5'd5;
        #1;
        n_checks++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || dbg_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_force: rd1=%h rd2=%h dbg=%h expected 0", rd1_b, rd2_b, dbg_b);
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) do_write(i[AW-1:0], 32'hDEADBEEF);
        dbg_ra = 5'd7; #1;
        n_checks++;
        if (dbg_b !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fill_r7: got %h expected deadbeef", dbg_b);
        end
        // Combinational force while reset asserted, before the edge.
        ra1 = 5'd7; rst_n = 1'b0; #1;
        n_checks++;
        if (rd1_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_force_rd1: got %h expected 0", rd1_b);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dbg_ra = i[AW-1:0]; #1;
            n_checks++;
            if (dbg_b !== 32'h0 || dbg_n !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_clear r%0d: got %h/%h expected 0", i, dbg_b, dbg_n);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'h00000007);
        do_write(5'd6, 32'hFFFFFFF9);
        ra1 = 5'd5; ra2 = 5'd6; #1;
        n_checks++;
        if (rd1_b !== 32'h7 || rd1_n !== 32'h7) begin
            n_fail++;
            $display("FAIL wr_rd1: got %h/%h expected 00000007", rd1_b, rd1_n);
        end
        n_checks++;
        if (rd2_b !== 32'hFFFFFFF9 || rd2_n !== 32'hFFFFFFF9) begin
            n_fail++;
            $display("FAIL wr_rd2: got %h/%h expected fffffff9", rd2_b, rd2_n);
        end
        // ADD of the two operands wraps to zero.
        n_checks++;
        if (32'(rd1_b + rd2_b) !== 32'h0) begin
            n_fail++;
            $display("FAIL alu_add_zero: got %h expected 0", 32'(rd1_b + rd2_b));
        end
    endtask

    task automatic test_r0();
        ra1 = 5'd0; ra2 = 5'd0; dbg_ra = 5'd0;
        we = 1'b1; wa = 5'd0; wd = 32'h12345678; #1;
        n_checks++;
        if (rd1_b !== 32'h0 || rd1_n !== 32'h0 || rd2_b !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_pre: got %h/%h/%h expected 0", rd1_b, rd1_n, rd2_b);
        end
        tick();
        we = 1'b0; #1;
        n_checks++;
        if (rd1_b !== 32'h0 || rd1_n !== 32'h0 || dbg_b !== 32'h0 || dbg_n !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_post: got %h/%h dbg %h/%h expected 0", rd1_b, rd1_n, dbg_b, dbg_n);
        end
    endtask

    task automatic test_bypass();
        do_write(5'd9, 32'h00000001);
        ra1 = 5'd9; ra2 = 5'd9; dbg_ra = 5'd9;
        we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5; #1;
        n_checks++;
        if (rd1_b !== 32'hA5A5A5A5 || rd2_b !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_on_pre: got %h/%h expected a5a5a5a5", rd1_b, rd2_b);
        end
        n_checks++;
        if (dbg_b !== 32'h1) begin
            n_fail++;
            $display("FAIL bypass_dbg: got %h expected 00000001", dbg_b);
        end
        n_checks++;
        if (rd1_n !== 32'h1 || rd2_n !== 32'h1) begin
            n_fail++;
            $display("FAIL bypass_off_pre: got %h/%h expected 00000001", rd1_n, rd2_n);
        end
        tick();
        we = 1'b0; #1;
        n_checks++;
        if (rd1_n !== 32'hA5A5A5A5 || rd2_n !== 32'hA5A5A5A5 || rd1_b !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_post: got %h/%h/%h expected a5a5a5a5", rd1_n, rd2_n, rd1_b);
        end
        // Disabled write must not forward even when addresses match.
        wa = 5'd9; wd = 32'h0BADF00D; we = 1'b0; #1;
        n_checks++;
        if (rd1_b !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_we_low: got %h expected a5a5a5a5", rd1_b);
        end
    endtask

    task automatic test_reset_mid_write();
        do_write(5'd3, 32'h00001234);
        rst_n = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'h0000FFFF;
        tick();
        rst_n = 1'b1; we = 1'b0; dbg_ra = 5'd3; #1;
        n_checks++;
        if (dbg_b !== 32'h0 || dbg_n !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_write: got %h/%h expected 0", dbg_b, dbg_n);
        end
        do_write(5'd3, 32'h0000FFFF);
        #1;
        n_checks++;
        if (dbg_b !== 32'h0000FFFF || dbg_n !== 32'h0000FFFF) begin
            n_fail++;
            $display("FAIL write_after_rst: got %h/%h expected 0000ffff", dbg_b, dbg_n);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e1b, e2b, e1n, e2n, ed;
        int           errs;
        errs = 0;
        rst_n = 1'b0; we = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int c = 0; c < 2000; c++) begin
            we     = ($urandom_range(0, 3) != 0);
            wa     = AW'($urandom_range(0, 31));
            wd     = $urandom;
            ra1    = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            ra2    = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            dbg_ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            #1;
            e1n = (ra1 == 0) ? '0 : model[ra1];
            e2n = (ra2 == 0) ? '0 : model[ra2];
            e1b = (ra1 != 0 && we && wa == ra1) ? wd : e1n;
            e2b = (ra2 != 0 && we && wa == ra2) ? wd : e2n;
            ed  = (dbg_ra == 0) ? '0 : model[dbg_ra];
            n_checks++;
            if (rd1_b !== e1b || rd2_b !== e2b || rd1_n !== e1n || rd2_n !== e2n ||
                dbg_b !== ed || dbg_n !== ed) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random cyc %0d: rd1 %h/%h rd2 %h/%h dbg %h/%h expected %h/%h %h/%h %h",
                             c, rd1_b, rd1_n, rd2_b, rd2_n, dbg_b, dbg_n, e1b, e1n, e2b, e2n, ed);
                errs++;
            end
            tick();
            if (we && wa != 0) model[wa] = wd;
        end
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0;
        ra1 = '0; ra2 = '0; dbg_ra = '0;
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file
